// File: rtl/reduce_gate_pkg.sv
// reduce_gate_pkg
// Shared definitions for the reduce_gate_pipe block:
//   mode_t      - per-beat reduction operation encoding (MODE_AND..MODE_RSVD)
//   POP_W       - width of the popcount used by the majority mode (covers WIDTH up to 64)
//   mode_apply  - turns primitive reductions into the result for a given mode
package reduce_gate_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_MAJ  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_t;

  localparam int POP_W = 7;

  // Select the reduction result for one mode; the reserved mode yields 0.
  function automatic logic mode_apply(
    input logic [2:0] mode,
    input logic       red_and,
    input logic       red_or,
    input logic       red_xor,
    input logic       maj
  );
    logic y;
    case (mode_t'(mode))
      MODE_AND:  y = red_and;
      MODE_OR:   y = red_or;
      MODE_XOR:  y = red_xor;
      MODE_NAND: y = ~red_and;
      MODE_NOR:  y = ~red_or;
      MODE_XNOR: y = ~red_xor;
      MODE_MAJ:  y = maj;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/reduce_gate_core.sv
// reduce_gate_core
// Combinational reduction of one bit group. Produces the primitive
// reductions every mode is built from, so the group can be the whole
// operand or one half of it when the reduction is split across stages.
// Ports:
//   data    in  WIDTH  bits of the group
//   red_and out 1      AND of the group
//   red_or  out 1      OR of the group
//   red_xor out 1      XOR of the group
//   pop     out POP_W  number of ones in the group
module reduce_gate_core
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic [POP_W-1:0] pop
);

  // Primitive reductions and population count of the group.
  always_comb begin
    red_and = &data;
    red_or  = |data;
    red_xor = ^data;
    pop     = {POP_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(data[i]);
    end
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe
// Pipelined WIDTH-bit reduction with a per-beat mode and valid/ready
// handshakes on both sides. STAGES register slices; each slice loads when it
// is empty or when the slice after it moves on, so bubbles collapse and a
// full pipe sustains one beat per cycle. For WIDTH > 8 with STAGES > 1 the
// first slice holds partial results of two bit groups and the second slice
// merges them.
// Optional build macro: REDUCE_GATE_STATS_EN adds saturating statistics
// outputs stat_beats / stat_ones.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      upstream beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_data    in   WIDTH  operand bits
//   in_mode    in   3      reduction mode for this beat
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_y      out  1      reduction result
//   out_mode   out  3      mode that produced out_y
//   stat_beats out  16     (macro only) output transfers, saturating
//   stat_ones  out  16     (macro only) transfers with out_y 1, saturating
module reduce_gate_pipe
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [2:0]       out_mode
`ifdef REDUCE_GATE_STATS_EN
  ,
  output logic [15:0]      stat_beats,
  output logic [15:0]      stat_ones
`endif
);

  localparam bit SPLIT = (WIDTH > 8) && (STAGES > 1);
  localparam int LO_W  = (WIDTH + 1) / 2;
  localparam int HI_W  = WIDTH - LO_W;
  localparam logic [POP_W-1:0] MAJ_THR = POP_W'(WIDTH / 2);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] ready;
  logic [2:0]        mode_pipe [STAGES];
  logic              y_pipe    [STAGES];
  logic              stage0_y;
  logic              stage1_y;
  logic              in_fire;

  // A slice may load when any slice from it to the output has room or the output drains.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    ready    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid[k];
      ready[k] = out_ready | ~all_full;
    end
  end

  assign in_ready = ready[0];
  assign in_fire  = in_valid & ready[0];

  if (SPLIT) begin : g_split
    logic             lo_and;
    logic             lo_or;
    logic             lo_xor;
    logic [POP_W-1:0] lo_pop;
    logic             hi_and;
    logic             hi_or;
    logic             hi_xor;
    logic [POP_W-1:0] hi_pop;
    logic [2:0]       part_lo;  // {and, or, xor}
    logic [2:0]       part_hi;
    logic [POP_W-1:0] pop_lo;
    logic [POP_W-1:0] pop_hi;

    reduce_gate_core #(.WIDTH(LO_W)) u_core_lo (
      .data    (in_data[LO_W-1:0]),
      .red_and (lo_and),
      .red_or  (lo_or),
      .red_xor (lo_xor),
      .pop     (lo_pop)
    );

    reduce_gate_core #(.WIDTH(HI_W)) u_core_hi (
      .data    (in_data[WIDTH-1:LO_W]),
      .red_and (hi_and),
      .red_or  (hi_or),
      .red_xor (hi_xor),
      .pop     (hi_pop)
    );

    // Group partials travel with stage 0; they only change on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        part_lo <= 3'd0;
        part_hi <= 3'd0;
        pop_lo  <= {POP_W{1'b0}};
        pop_hi  <= {POP_W{1'b0}};
      end else if (in_fire) begin
        part_lo <= {lo_and, lo_or, lo_xor};
        part_hi <= {hi_and, hi_or, hi_xor};
        pop_lo  <= lo_pop;
        pop_hi  <= hi_pop;
      end
    end

    // Merge the two group partials into the final result entering stage 1.
    always_comb begin
      stage1_y = mode_apply(mode_pipe[0],
                            part_lo[2] & part_hi[2],
                            part_lo[1] | part_hi[1],
                            part_lo[0] ^ part_hi[0],
                            (pop_lo + pop_hi) > MAJ_THR);
    end

    // Stage 0 carries partials instead of a finished result.
    assign stage0_y = 1'b0;
  end else begin : g_flat
    logic             f_and;
    logic             f_or;
    logic             f_xor;
    logic [POP_W-1:0] f_pop;

    reduce_gate_core #(.WIDTH(WIDTH)) u_core (
      .data    (in_data),
      .red_and (f_and),
      .red_or  (f_or),
      .red_xor (f_xor),
      .pop     (f_pop)
    );

    assign stage0_y = mode_apply(in_mode, f_and, f_or, f_xor, f_pop > MAJ_THR);
    assign stage1_y = y_pipe[0];
  end

  // Valid/data slices; payload loads only for a valid beat so idle inputs never propagate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        mode_pipe[k] <= 3'd0;
        y_pipe[k]    <= 1'b0;
      end
    end else begin
      if (ready[0]) begin
        valid[0] <= in_valid;
        if (in_valid) begin
          mode_pipe[0] <= in_mode;
          y_pipe[0]    <= stage0_y;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid[k] <= valid[k-1];
          if (valid[k-1]) begin
            mode_pipe[k] <= mode_pipe[k-1];
            y_pipe[k]    <= (k == 1) ? stage1_y : y_pipe[k-1];
          end
        end
      end
    end
  end

  assign out_valid = valid[STAGES-1];
  assign out_y     = y_pipe[STAGES-1];
  assign out_mode  = mode_pipe[STAGES-1];

`ifdef REDUCE_GATE_STATS_EN
  // Saturating counters of output transfers and of transfers carrying a 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats <= 16'd0;
      stat_ones  <= 16'd0;
    end else if (out_valid && out_ready) begin
      if (stat_beats != 16'hFFFF) begin
        stat_beats <= stat_beats + 16'd1;
      end
      if (out_y && (stat_ones != 16'hFFFF)) begin
        stat_ones <= stat_ones + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe
// Scoreboard bench for reduce_gate_pipe: dut_a (WIDTH=3, STAGES=2) and
// dut_b (WIDTH=16, STAGES=3, split reduction). Stimulus pushes expected
// {mode, y} per accepted beat; per-DUT monitors compare whenever a result is
// presented. Build with REDUCE_GATE_STATS_EN to also check the statistics.
module tb_reduce_gate_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [2:0]  in_mode;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y;
  logic [2:0]  a_out_mode;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y;
  logic [2:0]  b_out_mode;
`ifdef REDUCE_GATE_STATS_EN
  logic [15:0] a_stat_beats, a_stat_ones, b_stat_beats, b_stat_ones;
`endif

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int checks = 0;
  int fails = 0;
  int a_stalls = 0;
  int run = 0;
  int best_run = 0;
  int a_xfers = 0;
  int a_ones = 0;
  int b_xfers = 0;
  int b_ones = 0;

  always #5 clk = ~clk;

  reduce_gate_pipe #(.WIDTH(3), .STAGES(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data[2:0]),
    .in_mode   (in_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_y     (a_out_y),
    .out_mode  (a_out_mode)
`ifdef REDUCE_GATE_STATS_EN
    ,
    .stat_beats(a_stat_beats),
    .stat_ones (a_stat_ones)
`endif
  );

  reduce_gate_pipe #(.WIDTH(16), .STAGES(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_y     (b_out_y),
    .out_mode  (b_out_mode)
`ifdef REDUCE_GATE_STATS_EN
    ,
    .stat_beats(b_stat_beats),
    .stat_ones (b_stat_ones)
`endif
  );

  function automatic logic ref_y(input logic [15:0] d, input int w, input logic [2:0] m);
    logic a, o, x, y;
    int pop;
    a = 1'b1; o = 1'b0; x = 1'b0; pop = 0;
    for (int i = 0; i < w; i++) begin
      a = a & d[i];
      o = o | d[i];
      x = x ^ d[i];
      pop = pop + int'(d[i]);
    end
    case (m)
      3'd0: y = a;
      3'd1: y = o;
      3'd2: y = x;
      3'd3: y = ~a;
      3'd4: y = ~o;
      3'd5: y = ~x;
      3'd6: y = (pop > (w / 2));
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for dut_a: compare presented result with scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid) begin
        if (qa.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL a_spurious_result actual out_valid=1 required out_valid=0 at %0t", $time);
        end else begin
          check("a_result", {28'd0, a_out_mode, a_out_y}, {28'd0, qa[0]});
          if (a_out_ready) begin
            a_xfers++;
            a_ones += int'(qa[0][0]);
            void'(qa.pop_front());
          end
        end
      end
      if (a_out_valid && a_out_ready) run++;
      else run = 0;
      if (run > best_run) best_run = run;
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      if (qb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL b_spurious_result actual out_valid=1 required out_valid=0 at %0t", $time);
      end else begin
        check("b_result", {28'd0, b_out_mode, b_out_y}, {28'd0, qb[0]});
        if (b_out_ready) begin
          b_xfers++;
          b_ones += int'(qb[0][0]);
          void'(qb.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after transfer.
  task automatic send(input bit to_b, input logic [15:0] d, input logic [2:0] m, input logic e);
    bit done;
    int waits;
    done = 1'b0;
    waits = 0;
    in_data = d;
    in_mode = m;
    if (to_b) b_in_valid = 1'b1;
    else a_in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if ((to_b ? b_in_ready : a_in_ready) == 1'b1) begin
        if (to_b) qb.push_back({m, e});
        else qa.push_back({m, e});
        done = 1'b1;
      end else begin
        if (!to_b) a_stalls++;
        waits++;
        if (waits > 100) begin
          checks++;
          fails++;
          $display("FAIL send_timeout actual in_ready=0 required in_ready=1 at %0t", $time);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  sd [5];
    logic [2:0]  sm [5];
    logic        se [5];
    logic [15:0] rd;
    logic [2:0]  rm;
    int acc, nready, s0, cnt, waits;

    sd = '{3'b111, 3'b000, 3'b110, 3'b001, 3'b011};
    sm = '{3'd0,   3'd0,   3'd2,   3'd2,   3'd1};
    se = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1};

    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    in_data = 16'h0000;
    in_mode = 3'd0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("a_reset_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("a_reset_out_y", {31'd0, a_out_y}, 32'd0);
    check("a_reset_out_mode", {29'd0, a_out_mode}, 32'd0);
    check("a_reset_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("b_reset_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("b_reset_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("a_in_ready_after_reset", {31'd0, a_in_ready}, 32'd1);
    check("b_in_ready_after_reset", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: result exactly 2 cycles after transfer
    send(1'b0, 16'h0007, 3'd0, 1'b1);
    @(negedge clk);
    check("a_latency_early", {31'd0, a_out_valid}, 32'd0);
    @(negedge clk);
    check("a_latency_on_time", {31'd0, a_out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Hand-computed vectors
    send(1'b0, 16'h0006, 3'd2, 1'b0);  // 110 XOR
    send(1'b0, 16'h0006, 3'd6, 1'b1);  // 110 MAJ
    send(1'b0, 16'h0000, 3'd4, 1'b1);  // 000 NOR
    send(1'b0, 16'h0005, 3'd5, 1'b1);  // 101 XNOR
    send(1'b0, 16'h0003, 3'd3, 1'b1);  // 011 NAND
    send(1'b0, 16'h0002, 3'd7, 1'b0);  // reserved
    send(1'b0, 16'h0007, 3'd6, 1'b1);  // 111 MAJ
    send(1'b0, 16'h0001, 3'd6, 1'b0);  // 001 MAJ

    // Full truth table, all modes
    for (int m = 0; m < 8; m++) begin
      for (int d = 0; d < 8; d++) begin
        send(1'b0, 16'(d), 3'(m), ref_y(16'(d), 3, 3'(m)));
      end
    end
    idle(6);

    // Back-to-back burst of 8
    best_run = 0;
    s0 = a_stalls;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'(7 - i), 3'(i), ref_y(16'(7 - i), 3, 3'(i)));
    end
    idle(6);
    check("a_burst_in_ready_low_cycles", 32'(a_stalls - s0), 32'd0);
    check("a_burst_consecutive_results", 32'(best_run), 32'd8);

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    a_out_ready = 1'b0;
    acc = 0;
    nready = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = {13'd0, sd[acc]};
      in_mode = sm[acc];
      a_in_valid = 1'b1;
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back({sm[acc], se[acc]});
        acc++;
      end else begin
        nready++;
      end
      @(posedge clk);
      #1;
    end
    check("a_stall_accepted_beats", 32'(acc), 32'd2);
    check("a_stall_in_ready_low_cycles", 32'(nready), 32'd3);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("a_release_same_cycle_accept", {31'd0, a_in_ready}, 32'd1);
    if (a_in_ready) begin
      qa.push_back({sm[acc], se[acc]});
      acc++;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    while (acc < 5) begin
      send(1'b0, {13'd0, sd[acc]}, sm[acc], se[acc]);
      acc++;
    end
    idle(6);

    // Reset with two beats in flight
    a_out_ready = 1'b0;
    send(1'b0, 16'h0007, 3'd0, 1'b1);
    send(1'b0, 16'h0000, 3'd1, 1'b0);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    a_xfers = 0; a_ones = 0; b_xfers = 0; b_ones = 0;
    #1;
    check("a_rst_out_valid_immediate", {31'd0, a_out_valid}, 32'd0);
    check("a_rst_out_y", {31'd0, a_out_y}, 32'd0);
    check("a_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    a_out_ready = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_out_valid) cnt++;
    end
    check("a_no_stale_after_reset", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 16'h0005, 3'd2, 1'b0);
    idle(5);

    // Wide split pipeline: latency 3 then directed vectors
    send(1'b1, 16'h01FF, 3'd6, 1'b1);
    @(negedge clk);
    check("b_latency_c1", {31'd0, b_out_valid}, 32'd0);
    @(negedge clk);
    check("b_latency_c2", {31'd0, b_out_valid}, 32'd0);
    @(negedge clk);
    check("b_latency_c3", {31'd0, b_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    send(1'b1, 16'h00FF, 3'd6, 1'b0);
    send(1'b1, 16'h01FF, 3'd6, 1'b1);
    send(1'b1, 16'hFFFF, 3'd7, 1'b0);
    send(1'b1, 16'hFFFF, 3'd0, 1'b1);
    send(1'b1, 16'hFFFF, 3'd3, 1'b0);
    send(1'b1, 16'h0000, 3'd1, 1'b0);
    send(1'b1, 16'h0000, 3'd4, 1'b1);
    send(1'b1, 16'h8000, 3'd2, 1'b1);
    send(1'b1, 16'h8001, 3'd5, 1'b1);
    send(1'b1, 16'h0100, 3'd1, 1'b1);
    send(1'b1, 16'hFEFF, 3'd0, 1'b0);
    send(1'b1, 16'hFF01, 3'd6, 1'b1);
    for (int i = 0; i < 12; i++) begin
      rd = 16'($urandom);
      rm = 3'($urandom_range(0, 7));
      send(1'b1, rd, rm, ref_y(rd, 16, rm));
    end

    // Drain both scoreboards
    waits = 0;
    while (((qa.size() != 0) || (qb.size() != 0)) && (waits < 100)) begin
      @(posedge clk);
      waits++;
    end
    @(negedge clk);
    check("drain_a_empty", 32'(qa.size()), 32'd0);
    check("drain_b_empty", 32'(qb.size()), 32'd0);

`ifdef REDUCE_GATE_STATS_EN
    check("a_stat_beats", {16'd0, a_stat_beats}, 32'(a_xfers));
    check("a_stat_ones", {16'd0, a_stat_ones}, 32'(a_ones));
    check("b_stat_beats", {16'd0, b_stat_beats}, 32'(b_xfers));
    check("b_stat_ones", {16'd0, b_stat_ones}, 32'(b_ones));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
